// File: rtl/axis_latency_inject.sv
// axis_latency_inject: holds each AXI-Stream beat for a per-beat programmable delay, strict FIFO order
module axis_latency_inject #(
  parameter int DATA_WIDTH  = 512,
  parameter int DEPTH       = 16,
  parameter int DELAY_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DELAY_WIDTH-1:0]   cfg_delay,
  input  logic [DATA_WIDTH-1:0]    saxis_tdata,
  input  logic                     saxis_tvalid,
  output logic                     saxis_tready,
  output logic [DATA_WIDTH-1:0]    maxis_tdata,
  output logic                     maxis_tvalid,
  input  logic                     maxis_tready,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0]  data_q [DEPTH];
  logic [DATA_WIDTH-1:0]  data_d [DEPTH];
  logic [DELAY_WIDTH-1:0] cnt_q  [DEPTH];
  logic [DELAY_WIDTH-1:0] cnt_d  [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic                   push, pop;
  assign saxis_tready = !reset && count_q < (AW+1)'(DEPTH);
  assign maxis_tvalid = count_q != '0 && cnt_q[rd_ptr_q] == '0;
  assign maxis_tdata  = data_q[rd_ptr_q];
  assign occupancy    = count_q;
  assign push = saxis_tvalid && saxis_tready;
  assign pop  = maxis_tvalid && maxis_tready;
  // Free entries may age too; a write always reloads the countdown, so this is invisible.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
      cnt_d[i]  = cnt_q[i] - DELAY_WIDTH'(cnt_q[i] != '0);
    end
    if (push) begin
      data_d[wr_ptr_q] = saxis_tdata;
      cnt_d[wr_ptr_q]  = cfg_delay;
    end
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_axis_latency_inject.sv
// tb_axis_latency_inject: randomized scoreboard bench; model releases each beat at accept_cycle+1+delay in FIFO order
module tb_axis_latency_inject;
  localparam int DW = 512, DEPTH = 4, LW = 16;
  logic          clock, reset;
  logic [LW-1:0] cfg_delay;
  logic [DW-1:0] saxis_tdata, maxis_tdata;
  logic          saxis_tvalid, saxis_tready, maxis_tvalid, maxis_tready;
  logic [$clog2(DEPTH):0] occupancy;
  typedef struct { logic [DW-1:0] d; int rdy; } ent_t;
  ent_t q[$];
  int   cyc = 0, tests = 0, errs = 0;
  bit   acc_now = 0;
  axis_latency_inject #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DELAY_WIDTH(LW)) dut (
    .clock(clock), .reset(reset), .cfg_delay(cfg_delay),
    .saxis_tdata(saxis_tdata), .saxis_tvalid(saxis_tvalid), .saxis_tready(saxis_tready),
    .maxis_tdata(maxis_tdata), .maxis_tvalid(maxis_tvalid), .maxis_tready(maxis_tready),
    .occupancy(occupancy)
  );
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end
  always @(posedge clock) cyc <= cyc + 1;
  function automatic void chk(string n, logic [DW-1:0] a, logic [DW-1:0] e);
    tests++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
    end
  endfunction
  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  // Monitor: compares DUT outputs with the model state for the current cycle, pops on handshake.
  always @(negedge clock) begin
    int occ;
    bit ev;
    occ = q.size() - int'(acc_now);
    ev  = q.size() != 0 && cyc >= q[0].rdy;
    chk("tvalid", DW'(maxis_tvalid), DW'(ev));
    chk("tready", DW'(saxis_tready), DW'(!reset && occ < DEPTH));
    chk("occupancy", DW'(occupancy), DW'(occ));
    if (ev) begin
      chk("tdata", maxis_tdata, q[0].d);
      if (maxis_tready) void'(q.pop_front());
    end
  end
  task automatic step(input bit v, input logic [DW-1:0] d, input int dly, input bit rdy);
    @(posedge clock);
    #1;
    saxis_tvalid = v;
    saxis_tdata  = d;
    cfg_delay    = LW'(dly);
    maxis_tready = rdy;
    #3;
    acc_now = saxis_tvalid && saxis_tready;
    if (acc_now) q.push_back('{d: d, rdy: cyc + 1 + dly});
  endtask
  task automatic rst_pulse(input int hold);
    @(posedge clock);
    #2;
    reset = 1;
    saxis_tvalid = 0;
    q.delete();
    acc_now = 0;
    #1;
    chk("rst_tvalid", DW'(maxis_tvalid), '0);
    chk("rst_tready", DW'(saxis_tready), '0);
    chk("rst_occupancy", DW'(occupancy), '0);
    chk("rst_tdata", maxis_tdata, '0);
    repeat (hold) @(posedge clock);
    #1;
    reset = 0;
  endtask
  initial begin
    reset = 1;
    saxis_tvalid = 0;
    saxis_tdata = '0;
    cfg_delay = '0;
    maxis_tready = 1;
    repeat (3) @(posedge clock);
    #1;
    reset = 0;
    // single beat, delay 10
    step(1, {64{8'hA5}}, 10, 1);
    repeat (14) step(0, '0, 0, 1);
    // fill to full with delay 10
    for (int i = 0; i < 4; i++) step(1, {64{8'hB0 + 8'(i)}}, 10, 1);
    repeat (16) step(0, '0, 0, 1);
    // long delay followed by zero delay: head-of-line blocking
    step(1, {64{8'hAA}}, 20, 1);
    step(1, {64{8'hBB}}, 0, 1);
    repeat (24) step(0, '0, 0, 1);
    // held beat under backpressure stays stable
    step(1, {64{8'hC3}}, 10, 1);
    for (int i = 0; i < 40; i++) step(0, '0, 0, i >= 34);
    // zero delay streaming at full rate
    for (int i = 0; i < 64; i++) step(1, DW'(i + 1) ^ {DW/32{32'h5A5A0000}}, 0, 1);
    step(0, '0, 0, 1);
    // randomized traffic
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 9) < 7, rnd_data(), $urandom_range(0, 12), $urandom_range(0, 3) != 0);
    // three long-held beats discarded by mid-cycle reset
    for (int i = 0; i < 3; i++) step(1, rnd_data(), 50, 1);
    step(0, '0, 0, 1);
    rst_pulse(2);
    repeat (60) step(0, '0, 0, 1);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1) == 1, rnd_data(), $urandom_range(0, 5), $urandom_range(0, 1) == 1);
    for (int i = 0; i < 300 && q.size() != 0; i++) step(0, '0, 0, 1);
    tests++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain_timeout got=%0d beats left exp=0", q.size());
    end
    step(0, '0, 0, 1);
    @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
